// File: rtl/dds_pkg.sv
// Shared definitions for the tone sequencer: sequencer state encoding,
// DDS phase-increment width and note-duration width, plus the packed
// layout of one sequence-table entry.
package dds_pkg;

  localparam int K_W   = 22;
  localparam int DUR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic [K_W-1:0]   k;
    logic [DUR_W-1:0] dur;
  } entry_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   tick  - high for the one cycle where the count equals CLK_DIV-1
module sample_tick_gen #(
  parameter int CLK_DIV = 1042
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/tone_sequencer.sv
// Tone sequencer: steps through a small table of {phase increment, duration}
// entries and drives the phase increment of a DDS, with silent gaps between
// notes, optional looping and an abort input.
// Ports:
//   clk, reset              - system clock, async active-high reset
//   start, stop, loop_en    - sequencing control (stop has priority)
//   wr_en/wr_addr/wr_k/wr_dur - table write port, accepted in every state
//   k                       - phase increment to the DDS (0 = silence)
//   sampling_pulse          - one-cycle DDS sample strobe
//   busy                    - high in LOAD, PLAY and GAP
//   note_idx                - current table index
//   new_note, done          - one-cycle event pulses
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | silent, waiting for start
// LOAD  | one cycle; registered table entry is valid, decide PLAY/DONE
// PLAY  | k driven; counts beats of BEAT_SAMPLES sample pulses
// GAP   | silent for GAP_SAMPLES sample pulses before the next entry
// DONE  | one cycle; done pulses, back to IDLE
module tone_sequencer
  import dds_pkg::*;
#(
  parameter  int CLK_DIV      = 1042,
  parameter  int BEAT_SAMPLES = 4800,
  parameter  int GAP_SAMPLES  = 480,
  parameter  int SEQ_LEN      = 16,
  localparam int ADDR_W       = $clog2(SEQ_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [K_W-1:0]    wr_k,
  input  logic [DUR_W-1:0]  wr_dur,
  output logic [K_W-1:0]    k,
  output logic              sampling_pulse,
  output logic              busy,
  output logic [ADDR_W-1:0] note_idx,
  output logic              new_note,
  output logic              done
);

  localparam int BEAT_W = $clog2(BEAT_SAMPLES + 1);
  localparam int GAP_W  = (GAP_SAMPLES > 0) ? $clog2(GAP_SAMPLES + 1) : 1;
  localparam bit HAS_GAP = (GAP_SAMPLES > 0);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(SEQ_LEN - 1);

  state_t            state, state_nxt;
  state_t            adv_state;
  logic [ADDR_W-1:0] idx_nxt, adv_idx;
  logic [K_W-1:0]    k_nxt;
  logic              new_note_nxt, done_nxt;

  logic              tick;
  entry_t            table_mem [SEQ_LEN];
  entry_t            rd_q;

  logic [BEAT_W-1:0] beat_cnt;
  logic [DUR_W-1:0]  remaining;
  logic [GAP_W-1:0]  gap_cnt;
  logic              beat_wrap, note_end, gap_end, advance;

  sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign sampling_pulse = tick;

  // Table: the read address is the index the FSM is about to hold, so the
  // entry is already registered during the single LOAD cycle. A write to
  // that same index in the cycle before LOAD is forwarded.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      table_mem[wr_addr] <= {wr_k, wr_dur};
    end
    if (wr_en && (wr_addr == idx_nxt)) begin
      rd_q <= {wr_k, wr_dur};
    end else begin
      rd_q <= table_mem[idx_nxt];
    end
  end

  assign beat_wrap = (state == ST_PLAY) && tick && (beat_cnt == BEAT_LAST);
  assign note_end  = beat_wrap && (remaining == DUR_W'(1));
  assign gap_end   = (state == ST_GAP) && tick && (gap_cnt == GAP_W'(1));
  assign advance   = HAS_GAP ? gap_end : note_end;

  // State register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      note_idx <= '0;
      k        <= '0;
      new_note <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      note_idx <= idx_nxt;
      k        <= k_nxt;
      new_note <= new_note_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    adv_state = ST_LOAD;
    adv_idx   = note_idx + ADDR_W'(1);
    if (note_idx == LAST_IDX) begin
      adv_idx   = '0;
      adv_state = loop_en ? ST_LOAD : ST_DONE;
    end

    state_nxt = state;
    idx_nxt   = note_idx;
    if (stop) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_LOAD;
            idx_nxt   = '0;
          end
        end
        ST_LOAD: state_nxt = (rd_q.dur == '0) ? ST_DONE : ST_PLAY;
        ST_PLAY: begin
          if (advance) begin
            state_nxt = adv_state;
            idx_nxt   = adv_idx;
          end else if (note_end) begin
            state_nxt = ST_GAP;
          end
        end
        ST_GAP: begin
          if (advance) begin
            state_nxt = adv_state;
            idx_nxt   = adv_idx;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic; k, new_note and done are computed here and registered above
  always_comb begin
    k_nxt        = '0;
    new_note_nxt = 1'b0;
    done_nxt     = 1'b0;
    if (state_nxt == ST_PLAY) begin
      k_nxt = (state == ST_LOAD) ? rd_q.k : k;
    end
    new_note_nxt = (state == ST_LOAD) && (state_nxt == ST_PLAY);
    done_nxt     = (state_nxt == ST_DONE);
    busy = (state == ST_LOAD) || (state == ST_PLAY) || (state == ST_GAP);
  end

  // Beat, remaining-beat and gap counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt  <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
    end else if (stop) begin
      beat_cnt  <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          beat_cnt  <= '0;
          remaining <= rd_q.dur;
        end
        ST_PLAY: begin
          if (tick) begin
            if (beat_wrap) begin
              beat_cnt  <= '0;
              remaining <= remaining - DUR_W'(1);
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
          if (note_end) begin
            gap_cnt <= GAP_W'(GAP_SAMPLES);
          end
        end
        ST_GAP: begin
          if (tick) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [21:0]       wr_k = '0;
  logic [7:0]        wr_dur = '0;
  logic [21:0]       k;
  logic              sampling_pulse;
  logic              busy;
  logic [ADDR_W-1:0] note_idx;
  logic              new_note;
  logic              done;

  int checks = 0;
  int errors = 0;

  tone_sequencer #(
    .CLK_DIV(4), .BEAT_SAMPLES(2), .GAP_SAMPLES(1), .SEQ_LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_k(wr_k), .wr_dur(wr_dur),
    .k(k), .sampling_pulse(sampling_pulse), .busy(busy), .note_idx(note_idx),
    .new_note(new_note), .done(done)
  );

  always #5 clk = ~clk;

  task automatic write_entry(input int a, input logic [21:0] kv, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_k = kv; wr_dur = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_p;
    #1;
    checks++;
    if (k !== 22'h0 || busy !== 1'b0 || note_idx !== '0 || new_note !== 1'b0 ||
        done !== 1'b0 || sampling_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_values k=%h busy=%b idx=%0d nn=%b done=%b sp=%b required all 0",
               k, busy, note_idx, new_note, done, sampling_pulse);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    // sample i follows the i-th edge after release; the window holding the
    // release is cycle 1, so pulses land in cycles 4, 8, ...
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp_p = ((i + 1) % 4 == 0);
      checks++;
      if (sampling_pulse !== exp_p || k !== 22'h0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_pulse cycle=%0d sp=%b k=%h busy=%b required sp=%b k=0 busy=0",
                 i + 1, sampling_pulse, k, busy, exp_p);
      end
    end
  endtask

  task automatic test_sequence();
    logic [21:0] ek [4] = '{22'h1000, 22'h0, 22'h2000, 22'h0};
    int          en [4] = '{2, 1, 4, 1};
    logic [21:0] rk [$];
    int          rn [$];
    logic [21:0] cur_k;
    int          cur_n, nn;
    bit          rec, got_done;
    write_entry(0, 22'h1000, 8'd1);
    write_entry(1, 22'h2000, 8'd2);
    write_entry(2, 22'h3ff, 8'd0);
    loop_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rec = 0; got_done = 0; nn = 0; cur_n = 0; cur_k = '0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      if (new_note) nn++;
      if (!rec && k != 22'h0) begin rec = 1; cur_k = k; cur_n = 0; end
      if (rec) begin
        if (k !== cur_k) begin
          rk.push_back(cur_k); rn.push_back(cur_n); cur_k = k; cur_n = 0;
        end
        if (sampling_pulse) cur_n++;
        if (done) begin
          rk.push_back(cur_k); rn.push_back(cur_n); got_done = 1;
        end
      end
      if (!got_done) @(negedge clk);
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL seq_done_timeout done=0 required done pulse within 200 cycles");
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL seq_busy_at_done busy=%b required 0", busy);
    end
    checks++;
    if (rk.size() != 4) begin
      errors++;
      $display("FAIL seq_run_count runs=%0d required 4", rk.size());
    end else begin
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (rk[r] !== ek[r] || rn[r] != en[r]) begin
          errors++;
          $display("FAIL seq_run%0d k=%h pulses=%0d required k=%h pulses=%0d",
                   r, rk[r], rn[r], ek[r], en[r]);
        end
      end
    end
    checks++;
    if (nn != 2) begin
      errors++;
      $display("FAIL seq_new_note_count got=%0d required 2", nn);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || k !== 22'h0) begin
      errors++;
      $display("FAIL seq_after_done done=%b busy=%b k=%h required 0 0 0", done, busy, k);
    end
  endtask

  task automatic test_loop();
    int               nn, extra_nn;
    bit               cleared, fin, early_done;
    logic [ADDR_W-1:0] exp_idx;
    for (int i = 0; i < 4; i++) write_entry(i, 22'(22'h100 * (i + 1)), 8'd1);
    loop_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nn = 0; extra_nn = 0; cleared = 0; fin = 0; early_done = 0;
    for (int c = 0; c < 600 && !fin; c++) begin
      if (new_note) begin
        if (!cleared) begin
          exp_idx = ADDR_W'(nn % 4);
          checks++;
          if (note_idx !== exp_idx) begin
            errors++;
            $display("FAIL loop_idx note=%0d idx=%0d required %0d", nn, note_idx, exp_idx);
          end
          nn++;
          if (nn == 8) begin loop_en = 1'b0; cleared = 1; end
        end else begin
          extra_nn++;
        end
      end
      if (done) begin
        if (!cleared) early_done = 1;
        fin = 1;
      end
      if (!fin) @(negedge clk);
    end
    checks++;
    if (!fin || early_done) begin
      errors++;
      $display("FAIL loop_done fin=%b early=%b notes=%0d required done only after clearing loop_en",
               fin, early_done, nn);
    end
    checks++;
    if (extra_nn != 0 || nn != 8) begin
      errors++;
      $display("FAIL loop_note_count notes=%0d extra=%0d required 8 and 0", nn, extra_nn);
    end
    @(negedge clk);
  endtask

  task automatic test_stop();
    int  pc, bad;
    bit  found;
    write_entry(0, 22'h3000, 8'd1);
    write_entry(1, 22'h4000, 8'd2);
    write_entry(2, 22'h0, 8'd0);
    loop_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pc = 0; found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (k == 22'h4000 && sampling_pulse) pc++;
      if (pc == 2) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stop_reach_beat2 pulses=%0d required 2 within 200 cycles", pc);
    end
    @(negedge clk);
    checks++;
    if (k !== 22'h4000 || note_idx !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_pre k=%h idx=%0d busy=%b required 4000 1 1", k, note_idx, busy);
    end
    stop = 1'b1; start = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    checks++;
    if (k !== 22'h0 || busy !== 1'b0 || note_idx !== 2'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL stop_abort k=%h busy=%b idx=%0d done=%b required 0 0 0 0",
               k, busy, note_idx, done);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || new_note !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stop_start_ignored bad_cycles=%0d required 0", bad);
    end
  endtask

  task automatic test_dur_zero();
    logic exp_done, exp_busy;
    write_entry(0, 22'h5000, 8'd0);
    start = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      @(negedge clk);
      start = 1'b0;
      exp_done = (s == 2);
      exp_busy = (s == 1);
      checks++;
      if (done !== exp_done || busy !== exp_busy || new_note !== 1'b0 || k !== 22'h0) begin
        errors++;
        $display("FAIL dur0 cycle=%0d done=%b busy=%b nn=%b k=%h required done=%b busy=%b nn=0 k=0",
                 s, done, busy, new_note, k, exp_done, exp_busy);
      end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    int bad;
    write_entry(0, 22'h6000, 8'd1);
    write_entry(1, 22'h7000, 8'd3);
    write_entry(2, 22'h0, 8'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (new_note && note_idx == 2'd1) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL areset_reach_note1 required new_note at idx 1 within 200 cycles");
    end
    @(negedge clk); @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (k !== 22'h0 || busy !== 1'b0 || note_idx !== '0 || new_note !== 1'b0 ||
        done !== 1'b0 || sampling_pulse !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate k=%h busy=%b idx=%0d nn=%b done=%b sp=%b required all 0",
               k, busy, note_idx, new_note, done, sampling_pulse);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || k !== 22'h0 || done !== 1'b0 || new_note !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL areset_stays_idle bad_cycles=%0d required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_loop();
    test_stop();
    test_dur_zero();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1042, meaning clocks per sampling_pulse (50 MHz / 48 kHz).
REQ-002 SHALL have parameter BEAT_SAMPLES, default 4800, meaning sampling pulses per duration unit.
REQ-003 SHALL have parameter GAP_SAMPLES, default 480, meaning silent sampling pulses between notes (0 = no gap).
REQ-004 SHALL have parameter SEQ_LEN, default 16, meaning table entries; ADDR_W = clog2(SEQ_LEN).
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 start  in  1  one-cycle request to begin at entry 0.
REQ-009 stop  in  1  one-cycle abort request.
REQ-010 loop_en  in  1  after the last entry, restart at entry 0 instead of finishing.
REQ-011 wr_en  in  1  table write strobe.
REQ-012 wr_addr  in  ADDR_W  table write index.
REQ-013 wr_k  in  22  phase increment for the entry.
REQ-014 wr_dur  in  8  duration in beats; 0 = end-of-sequence marker.
REQ-015 k  out  22  phase increment to the DDS.
REQ-016 sampling_pulse  out  1  one-cycle DDS sample strobe.
REQ-017 busy  out  1  high in LOAD, PLAY and GAP.
REQ-018 note_idx  out  ADDR_W  current table index.
REQ-019 new_note  out  1  one-cycle pulse on entering PLAY.
REQ-020 done  out  1  one-cycle pulse on sequence completion.

Function
REQ-021 sampling_pulse SHALL free-run in every state: divider counts 0..CLK_DIV-1, and the pulse is high for the one cycle where the count equals CLK_DIV-1; the first pulse occurs CLK_DIV cycles after reset release.
REQ-022 The table SHALL hold SEQ_LEN entries of {k, dur}; a write takes effect for any LOAD occurring at least one cycle later; writes are accepted in all states.
REQ-023 The FSM SHALL have states IDLE, LOAD, PLAY, GAP and DONE.
REQ-024 IDLE: k=0; start moves to LOAD with note_idx=0 on the next cycle.
REQ-025 LOAD (1 cycle, registered table read): dur=0 goes to DONE; otherwise k<=entry.k, remaining<=dur, beat count<=0, new_note pulses, and the FSM goes to PLAY.
REQ-026 PLAY: each sampling_pulse increments the beat count; at BEAT_SAMPLES-1 the count wraps to 0 and remaining decrements; 1->0 goes to GAP; a note lasts exactly dur*BEAT_SAMPLES pulses.
REQ-027 GAP: k=0 for GAP_SAMPLES pulses (skipped if 0), then note_idx+1 and LOAD; at note_idx=SEQ_LEN-1, the FSM goes to LOAD with index 0 if loop_en (sampled at that transition), else to DONE.
REQ-028 DONE: done pulses for one cycle, k=0, and the FSM returns to IDLE.
REQ-029 stop SHALL take priority over all other events: from any state, the next cycle is IDLE, k=0, note_idx=0, with no done pulse.
REQ-030 start while busy SHALL be ignored; start and stop in the same cycle SHALL give stop.
REQ-031 k, new_note and done SHALL be registered outputs.

Reset
REQ-032 On reset: state=IDLE, k=0, sampling_pulse=0, divider=0, busy=0, note_idx=0, new_note=0, done=0, beat/remaining/gap counters=0; table contents are undefined (not reset).
REQ-033 Reset mid-sequence SHALL abort immediately; sequencing resumes only on a new start after release.

Structure
REQ-034 Shared package dds_pkg SHALL hold the state encoding, K_W=22 and DUR_W=8.
REQ-035 The sampling-pulse divider SHALL be a sub-module sample_tick_gen (parameter CLK_DIV; ports clk, reset, tick).

Verification (CLK_DIV=4, BEAT_SAMPLES=2, GAP_SAMPLES=1, SEQ_LEN=4)
REQ-036 Reset, idle 20 cycles -> sampling_pulse every 4th cycle (first at cycle 4), k=0, busy=0.
REQ-037 Table {0x1000,1},{0x2000,2},{x,0}; start -> k=0x1000 for 2 pulses, k=0 for 1 pulse, k=0x2000 for 4 pulses, k=0 for 1 pulse, then done pulse, busy=0.
REQ-038 All 4 entries dur=1 with loop_en=1 -> note_idx sequence 0,1,2,3,0,... with no done pulse; clearing loop_en during entry 3 -> done after its gap.
REQ-039 stop during the second beat of a note -> next cycle k=0, busy=0, note_idx=0, done=0; a start issued in the same cycle as stop is ignored.
REQ-040 Entry 0 dur=0, start -> LOAD, then DONE, then IDLE; done is high exactly 2 cycles after start and new_note never asserts.
REQ-041 Async reset asserted mid-PLAY between clock edges -> all outputs at reset values before the next edge.
